// File: rtl/fft_bitrev_reorder_pkg.sv
// Shared FFT definitions: default sizes, reorder FSM states and a bit-reversal helper
// usable by any FFT stage (reorder, twiddle ROM addressing).
package fft_bitrev_reorder_pkg;

  localparam int DEF_LOG_N = 6;
  localparam int DEF_WIDTH = 16;
  localparam int MAX_LOG_N = 16;

  typedef enum logic {
    ST_IDLE,
    ST_READ
  } rd_state_e;

  // Reverses the low 'bits' bits of v; callers truncate the result to their width.
  function automatic logic [MAX_LOG_N-1:0] bitrev(input logic [MAX_LOG_N-1:0] v,
                                                  input int unsigned bits);
    logic [MAX_LOG_N-1:0] r;
    r = {<<{v}};
    return r >> (MAX_LOG_N - bits);
  endfunction

endpackage

// File: rtl/fft_reorder_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset so it maps
// onto block RAM. The read register holds its value while rd_en is low.
module fft_reorder_ram #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_reg [2**ADDR_W];

  always_ff @(posedge clock) begin
    if (wr_en) mem_reg[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem_reg[rd_addr];
  end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Converts bit-reversed FFT output frames into natural bin order using a ping-pong RAM:
// one bank fills at bit-reversed addresses while the other is read out sequentially.
module fft_bitrev_reorder
  import fft_bitrev_reorder_pkg::*;
#(
  parameter int LOG_N = DEF_LOG_N,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             di_en,
  input  logic [WIDTH-1:0] di_re,
  input  logic [WIDTH-1:0] di_im,
  output logic             do_en,
  output logic [WIDTH-1:0] do_re,
  output logic [WIDTH-1:0] do_im,
  output logic [LOG_N-1:0] do_idx
);

  logic [LOG_N-1:0]   wcnt_reg;
  logic [LOG_N-1:0]   rcnt_reg;
  logic [LOG_N-1:0]   idx_reg;
  logic [LOG_N-1:0]   wr_idx;
  logic               wbank_reg;
  logic               rbank_reg;
  logic [1:0]         full_reg;
  logic [1:0]         full_set;
  logic [1:0]         full_clr;
  rd_state_e          state_reg;
  logic               do_en_reg;
  logic               data_valid_reg;
  logic               wr_last;
  logic               rd_en;
  logic               rd_last;
  logic [2*WIDTH-1:0] rd_data;

  assign wr_idx  = LOG_N'(bitrev(MAX_LOG_N'(wcnt_reg), LOG_N));
  assign wr_last = di_en && (wcnt_reg == '1);
  assign rd_en   = (state_reg == ST_READ);
  assign rd_last = rd_en && (rcnt_reg == '1);

  fft_reorder_ram #(
    .ADDR_W(LOG_N + 1),
    .DATA_W(2 * WIDTH)
  ) u_ram (
    .clock  (clock),
    .wr_en  (di_en),
    .wr_addr({wbank_reg, wr_idx}),
    .wr_data({di_re, di_im}),
    .rd_en  (rd_en),
    .rd_addr({rbank_reg, rcnt_reg}),
    .rd_data(rd_data)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wcnt_reg  <= '0;
      wbank_reg <= 1'b0;
    end else if (di_en) begin
      wcnt_reg <= wcnt_reg + 1'b1;
      if (wr_last) wbank_reg <= ~wbank_reg;
    end
  end

  // Writer and reader always work on different banks, so set and clear never collide.
  for (genvar gi = 0; gi < 2; gi++) begin : g_full
    assign full_set[gi] = wr_last && (wbank_reg == 1'(gi));
    assign full_clr[gi] = rd_last && (rbank_reg == 1'(gi));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) full_reg <= '0;
    else       full_reg <= (full_reg | full_set) & ~full_clr;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      rcnt_reg       <= '0;
      rbank_reg      <= 1'b0;
      do_en_reg      <= 1'b0;
      idx_reg        <= '0;
      data_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          do_en_reg <= 1'b0;
          if (full_reg[rbank_reg]) begin
            state_reg <= ST_READ;
            rcnt_reg  <= '0;
          end
        end
        ST_READ: begin
          do_en_reg      <= 1'b1;
          idx_reg        <= rcnt_reg;
          data_valid_reg <= 1'b1;
          rcnt_reg       <= rcnt_reg + 1'b1;
          if (rcnt_reg == '1) begin
            rbank_reg <= ~rbank_reg;
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // The RAM read register has no reset; gate it so outputs read zero until the first read.
  assign do_en  = do_en_reg;
  assign do_idx = idx_reg;
  assign do_re  = data_valid_reg ? rd_data[2*WIDTH-1:WIDTH] : '0;
  assign do_im  = data_valid_reg ? rd_data[WIDTH-1:0] : '0;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Scoreboard bench for fft_bitrev_reorder with N=8: stimulus pushes natural-order
// expectations, an independent monitor pops and compares on every do_en.
module tb_fft_bitrev_reorder;

  localparam int LOG_N = 3;
  localparam int WIDTH = 16;

  typedef struct {
    logic [WIDTH-1:0] re;
    logic [WIDTH-1:0] im;
    logic [LOG_N-1:0] idx;
    int               lat_edge;
    int               gap_max;
  } exp_t;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             di_en = 1'b0;
  logic [WIDTH-1:0] di_re = '0;
  logic [WIDTH-1:0] di_im = '0;
  logic             do_en;
  logic [WIDTH-1:0] do_re;
  logic [WIDTH-1:0] do_im;
  logic [LOG_N-1:0] do_idx;

  exp_t             sb[$];
  int               n_total = 0;
  int               n_pass = 0;
  int               edge_cnt = 0;
  int               last_out_edge = -1;
  int               brv[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
  logic [WIDTH-1:0] fr_re[8];
  logic [WIDTH-1:0] fr_im[8];

  fft_bitrev_reorder #(.LOG_N(LOG_N), .WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .di_en (di_en),
    .di_re (di_re),
    .di_im (di_im),
    .do_en (do_en),
    .do_re (do_re),
    .do_im (do_im),
    .do_idx(do_idx)
  );

  always #5 clock = ~clock;
  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
  endtask

  // Monitor: every presented output must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (!reset && do_en) begin
      if (sb.size() == 0) begin
        check("unexpected_do_en", 32'(do_idx), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("do_re", 32'(do_re), 32'(e.re));
        check("do_im", 32'(do_im), 32'(e.im));
        check("do_idx", 32'(do_idx), 32'(e.idx));
        if (e.lat_edge >= 0) check("latency_edge", 32'(edge_cnt), 32'(e.lat_edge));
        else if (last_out_edge >= 0) check("gap_ok", 32'(edge_cnt - last_out_edge <= e.gap_max), 32'd1);
        $display("out idx=%0d re=%04h im=%04h edge=%0d", do_idx, do_re, do_im, edge_cnt);
      end
      last_out_edge = edge_cnt;
    end
  end

  task automatic set_frame(input int base);
    for (int i = 0; i < 8; i++) begin
      fr_re[i] = 16'(base + i);
      fr_im[i] = 16'(100 + base + i);
    end
  endtask

  // exact=1: reader is idle, so the first output lands exactly 2 edges after the last sample.
  task automatic send_frame(input bit gapped, input bit exact);
    int last;
    for (int p = 0; p < 8; p++) begin
      di_en = 1'b1;
      di_re = fr_re[brv[p]];
      di_im = fr_im[brv[p]];
      @(posedge clock); #1;
      if (gapped && p < 7) begin
        di_en = 1'b0;
        @(posedge clock); #1;
      end
    end
    di_en = 1'b0;
    last = edge_cnt;
    for (int i = 0; i < 8; i++) begin
      exp_t e;
      e.re = fr_re[i];
      e.im = fr_im[i];
      e.idx = 3'(i);
      e.lat_edge = (i == 0 && exact) ? last + 2 : -1;
      e.gap_max = (i == 0) ? 2 : 1;
      sb.push_back(e);
    end
    $display("frame sent re0=%04h last_edge=%0d gapped=%0d", fr_re[0], last, gapped);
  endtask

  task automatic wait_drain();
    int cyc = 0;
    while (sb.size() != 0 && cyc < 100) begin
      @(posedge clock); #1;
      cyc++;
    end
    repeat (4) @(posedge clock);
    #1;
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_do_en", 32'(do_en), 32'd0);
    check("rst_do_re", 32'(do_re), 32'd0);
    check("rst_do_im", 32'(do_im), 32'd0);
    check("rst_do_idx", 32'(do_idx), 32'd0);
    sb.delete();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    last_out_edge = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    do_reset();

    // Single frame
    set_frame(0);
    send_frame(1'b0, 1'b1);
    wait_drain();

    // Three back-to-back frames, offset 16 per frame
    for (int k = 0; k < 3; k++) begin
      set_frame(16 * k);
      send_frame(1'b0, k == 0);
    end
    wait_drain();

    // Gapped input
    set_frame(0);
    send_frame(1'b1, 1'b1);
    wait_drain();

    // Mid-frame reset after 5 samples
    for (int p = 0; p < 5; p++) begin
      di_en = 1'b1;
      di_re = 16'hDEAD;
      di_im = 16'hBEEF;
      @(posedge clock); #1;
    end
    di_en = 1'b0;
    do_reset();
    repeat (12) @(posedge clock);
    #1;
    set_frame(0);
    send_frame(1'b0, 1'b1);
    wait_drain();

    // Reset during readout at do_idx==3
    set_frame(32);
    send_frame(1'b0, 1'b1);
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
    end while (!(do_en && do_idx == 3'd3) && cyc < 50);
    check("saw_idx3", 32'(do_en && do_idx == 3'd3), 32'd1);
    #2;
    do_reset();
    repeat (12) @(posedge clock);
    #1;
    set_frame(48);
    send_frame(1'b0, 1'b1);
    wait_drain();

    // Sign-extreme passthrough
    for (int i = 0; i < 8; i++) begin
      fr_re[i] = (i % 2 == 0) ? 16'h8000 : 16'h7FFF;
      fr_im[i] = (i % 2 == 0) ? 16'h7FFF : 16'h8000;
    end
    send_frame(1'b0, 1'b1);
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
